// File: rtl/eh2_lsu_trigger_seq_pkg.sv
// Shared packet types for the LSU trigger unit and its dc3/dc4 pipe interface.
package eh2_lsu_trigger_seq_pkg;

  localparam int TIDW = 1;

  typedef struct packed {
    logic            valid;
    logic [TIDW-1:0] tid;
    logic            by;
    logic            half;
    logic            word;
    logic            dword;
    logic            load;
    logic            store;
    logic            atomic;
    logic            dma;
  } eh2_lsu_pkt_t;

  typedef struct packed {
    logic        m;
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic [31:0] tdata2;
  } eh2_trigger_pkt_t;

endpackage

// File: rtl/eh2_lsu_trigger_seq_if.sv
// LSU dc3/dc4 pipe signals seen by the trigger unit, plus the dc4 match result.
interface eh2_lsu_trigger_seq_if #(parameter int NUM_TRIG = 4);
  import eh2_lsu_trigger_seq_pkg::*;

  eh2_lsu_pkt_t          lsu_pkt_dc3;
  eh2_lsu_pkt_t          lsu_pkt_dc4;
  logic                  lsu_kill_dc4;
  logic [31:0]           lsu_addr_dc4;
  logic [31:0]           store_data_dc3;
  logic [31:0]           amo_data_dc3;
  logic [NUM_TRIG-1:0]   lsu_trigger_match_dc4;

  modport master (
    output lsu_pkt_dc3, lsu_pkt_dc4, lsu_kill_dc4, lsu_addr_dc4,
           store_data_dc3, amo_data_dc3,
    input  lsu_trigger_match_dc4
  );

  modport slave (
    input  lsu_pkt_dc3, lsu_pkt_dc4, lsu_kill_dc4, lsu_addr_dc4,
           store_data_dc3, amo_data_dc3,
    output lsu_trigger_match_dc4
  );
endinterface

// File: rtl/eh2_lsu_trigger_seq.sv
// Per-thread LSU debug triggers: mask/range compare, even/odd chaining, match-count gating, sticky hits.
// Match output is combinational in dc4; store data is captured one stage earlier in dc3.
module eh2_lsu_trigger_seq
  import eh2_lsu_trigger_seq_pkg::*;
#(
  parameter int  NUM_THREADS = 2,
  parameter int  NUM_TRIG    = 4,
  parameter int  CNTW        = 8,
  localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int IW          = $clog2(NUM_TRIG)
) (
  input  logic                clk,
  input  logic                rst_l,
  input  logic                scan_mode,
  input  logic                clk_override,
  input  eh2_trigger_pkt_t    trigger_pkt_any [NUM_THREADS][NUM_TRIG],
  input  logic [1:0]          trig_mode_any   [NUM_THREADS][NUM_TRIG],
  input  logic [NUM_TRIG-1:0] trig_chain_any  [NUM_THREADS],
  input  logic                trig_cnt_wr,
  input  logic [TW-1:0]       trig_cnt_tid,
  input  logic [IW-1:0]       trig_cnt_idx,
  input  logic [CNTW-1:0]     trig_cnt_wdata,
  input  logic [NUM_TRIG-1:0] trig_hit_clr    [NUM_THREADS],
  eh2_lsu_trigger_seq_if.slave lsu,
  output logic [NUM_TRIG-1:0] lsu_trigger_hit [NUM_THREADS],
  output logic [CNTW-1:0]     trig_cnt_rdata  [NUM_THREADS][NUM_TRIG]
);

  logic                trig_en;
  logic                qual;
  logic [TW-1:0]       tid;
  logic [31:0]         data_dc3;
  logic [31:0]         sd_fmt_dc3;
  logic                sd_en;
  logic [31:0]         sd_dc4;
  logic [31:0]         addr_op;
  logic [31:0]         sd_op;
  eh2_trigger_pkt_t    tp;
  logic [31:0]         op;
  logic                cmp;
  logic                type_hit;
  logic [NUM_TRIG-1:0] raw;
  logic [NUM_TRIG-1:0] ch;
  logic [NUM_TRIG-1:0] pre;
  logic [NUM_TRIG-1:0] fire;
  logic                unused_sig;

  // Bit 0 is always a wildcard under masken; higher bits become wildcards while all lower mask bits are 1.
  function automatic logic mask_match(input logic [31:0] data, input logic [31:0] mask,
                                      input logic masken);
    logic wild;
    logic all_lo;
    logic ok;
    wild   = masken & ~(&mask);
    ok     = wild | (mask[0] == data[0]);
    all_lo = mask[0];
    for (int b = 1; b < 32; b++) begin
      ok     = ok & ((all_lo & wild) | (mask[b] == data[b]));
      all_lo = all_lo & mask[b];
    end
    return ok;
  endfunction

  always_comb begin
    trig_en = 1'b0;
    for (int t = 0; t < NUM_THREADS; t++)
      for (int i = 0; i < NUM_TRIG; i++)
        trig_en = trig_en | trigger_pkt_any[t][i].m;
  end

  assign data_dc3   = lsu.lsu_pkt_dc3.atomic ? lsu.amo_data_dc3 : lsu.store_data_dc3;
  assign sd_fmt_dc3 = {data_dc3[31:16] & {16{lsu.lsu_pkt_dc3.word | lsu.lsu_pkt_dc3.dword}},
                       data_dc3[15:8]  & {8{~lsu.lsu_pkt_dc3.by}},
                       data_dc3[7:0]};
  assign sd_en      = (lsu.lsu_pkt_dc3.valid & lsu.lsu_pkt_dc3.store & trig_en) | clk_override;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)     sd_dc4 <= '0;
    else if (sd_en) sd_dc4 <= sd_fmt_dc3;
  end

  assign tid     = TW'(lsu.lsu_pkt_dc4.tid);
  assign qual    = lsu.lsu_pkt_dc4.valid & ~lsu.lsu_pkt_dc4.dma & ~lsu.lsu_kill_dc4;
  assign addr_op = lsu.lsu_addr_dc4 & {32{trig_en}};
  assign sd_op   = sd_dc4 & {32{trig_en}};

  always_comb begin
    tp       = '0;
    op       = '0;
    cmp      = 1'b0;
    type_hit = 1'b0;
    raw      = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      tp = trigger_pkt_any[tid][i];
      if (!tp.select)                 op = addr_op;
      else if (lsu.lsu_pkt_dc4.store) op = sd_op;
      else                            op = '0;
      case (trig_mode_any[tid][i])
        2'b00:   cmp = mask_match(op, tp.tdata2, tp.match);
        2'b01:   cmp = (op >= tp.tdata2);
        2'b10:   cmp = (op <  tp.tdata2);
        default: cmp = 1'b0;
      endcase
      type_hit = (tp.store & lsu.lsu_pkt_dc4.store) |
                 (tp.load & lsu.lsu_pkt_dc4.load & ~lsu.lsu_pkt_dc4.store & ~tp.select);
      raw[i]   = qual & type_hit & cmp;
    end
  end

  // Chained pairs gate on each member's own counter, then both must fire.
  always_comb begin
    ch = raw;
    for (int i = 0; i < NUM_TRIG - 1; i += 2) begin
      if (trig_chain_any[tid][i]) begin
        ch[i]     = raw[i] & raw[i+1];
        ch[i+1]   = ch[i];
      end
    end
    for (int i = 0; i < NUM_TRIG; i++)
      pre[i] = ch[i] & (trig_cnt_rdata[tid][i] <= CNTW'(1));
    fire = pre;
    for (int i = 0; i < NUM_TRIG - 1; i += 2) begin
      if (trig_chain_any[tid][i]) begin
        fire[i]   = pre[i] & pre[i+1];
        fire[i+1] = fire[i];
      end
    end
  end

  assign lsu.lsu_trigger_match_dc4 = fire;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        lsu_trigger_hit[t] <= '0;
        for (int i = 0; i < NUM_TRIG; i++)
          trig_cnt_rdata[t][i] <= '0;
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        for (int i = 0; i < NUM_TRIG; i++) begin
          if (trig_cnt_wr && (trig_cnt_tid == TW'(t)) && (trig_cnt_idx == IW'(i)))
            trig_cnt_rdata[t][i] <= trig_cnt_wdata;
          else if ((tid == TW'(t)) && ch[i] && (trig_cnt_rdata[t][i] != '0))
            trig_cnt_rdata[t][i] <= trig_cnt_rdata[t][i] - CNTW'(1);
          if ((tid == TW'(t)) && fire[i])
            lsu_trigger_hit[t][i] <= 1'b1;
          else if (trig_hit_clr[t][i])
            lsu_trigger_hit[t][i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    unused_sig = scan_mode ^ (^lsu.lsu_pkt_dc3) ^ (^lsu.lsu_pkt_dc4);
    for (int t = 0; t < NUM_THREADS; t++)
      unused_sig = unused_sig ^ (^trig_chain_any[t]);
  end

endmodule

// File: tb/tb_eh2_lsu_trigger_seq.sv
// Bench for eh2_lsu_trigger_seq: directed scenarios then randomized traffic against a behavioural model.
module tb_eh2_lsu_trigger_seq;
  import eh2_lsu_trigger_seq_pkg::*;

  localparam int NT = 2;
  localparam int NG = 4;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             scan_mode = 1'b0;
  logic             clk_override = 1'b0;
  eh2_trigger_pkt_t trig [NT][NG];
  logic [1:0]       mode [NT][NG];
  logic [NG-1:0]    chain [NT];
  logic             cnt_wr;
  logic [0:0]       cnt_tid;
  logic [1:0]       cnt_idx;
  logic [CW-1:0]    cnt_wdata;
  logic [NG-1:0]    hit_clr [NT];
  logic [NG-1:0]    hit [NT];
  logic [CW-1:0]    cnt_rd [NT][NG];

  eh2_lsu_trigger_seq_if #(.NUM_TRIG(NG)) lsu ();

  eh2_lsu_trigger_seq #(.NUM_THREADS(NT), .NUM_TRIG(NG), .CNTW(CW)) dut (
    .clk(clk), .rst_l(rst_l), .scan_mode(scan_mode), .clk_override(clk_override),
    .trigger_pkt_any(trig), .trig_mode_any(mode), .trig_chain_any(chain),
    .trig_cnt_wr(cnt_wr), .trig_cnt_tid(cnt_tid), .trig_cnt_idx(cnt_idx),
    .trig_cnt_wdata(cnt_wdata), .trig_hit_clr(hit_clr), .lsu(lsu),
    .lsu_trigger_hit(hit), .trig_cnt_rdata(cnt_rd)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          m_cnt [NT][NG];
  bit          m_hit [NT][NG];
  logic [31:0] m_sd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit any_m();
    bit en = 1'b0;
    foreach (trig[a, b]) en |= trig[a][b].m;
    return en;
  endfunction

  function automatic bit cmp_ok(logic [31:0] op, logic [31:0] td, logic [1:0] md, bit masken);
    int k;
    case (md)
      2'b00: begin
        if (!masken || td == 32'hFFFF_FFFF) return op == td;
        k = 0;
        while (td[k]) k++;
        return (op >> (k + 1)) == (td >> (k + 1));
      end
      2'b01:   return op >= td;
      2'b10:   return op < td;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [NG-1:0] model_fire(output logic [NG-1:0] ch_o);
    eh2_lsu_pkt_t     p;
    eh2_trigger_pkt_t tp;
    int               t;
    bit               en;
    bit               qual;
    logic [31:0]      op;
    logic [NG-1:0]    raw;
    logic [NG-1:0]    gate;
    logic [NG-1:0]    res;
    p    = lsu.lsu_pkt_dc4;
    t    = int'(p.tid);
    en   = any_m();
    qual = p.valid && !p.dma && !lsu.lsu_kill_dc4;
    for (int i = 0; i < NG; i++) begin
      tp = trig[t][i];
      if (!tp.select)   op = en ? lsu.lsu_addr_dc4 : 32'h0;
      else if (p.store) op = en ? m_sd : 32'h0;
      else              op = 32'h0;
      raw[i] = qual && ((tp.store && p.store) || (tp.load && p.load && !p.store && !tp.select))
               && cmp_ok(op, tp.tdata2, mode[t][i], tp.match);
    end
    ch_o = raw;
    for (int i = 0; i + 1 < NG; i += 2)
      if (chain[t][i]) begin
        ch_o[i]   = raw[i] && raw[i+1];
        ch_o[i+1] = ch_o[i];
      end
    for (int i = 0; i < NG; i++) gate[i] = ch_o[i] && (m_cnt[t][i] <= 1);
    res = gate;
    for (int i = 0; i + 1 < NG; i += 2)
      if (chain[t][i]) begin
        res[i]   = gate[i] && gate[i+1];
        res[i+1] = res[i];
      end
    return res;
  endfunction

  task automatic model_step(input logic [NG-1:0] f, input logic [NG-1:0] ch);
    eh2_lsu_pkt_t d3;
    logic [31:0]  v;
    int           t;
    t  = int'(lsu.lsu_pkt_dc4.tid);
    d3 = lsu.lsu_pkt_dc3;
    for (int tt = 0; tt < NT; tt++)
      for (int i = 0; i < NG; i++) begin
        if (cnt_wr && int'(cnt_tid) == tt && int'(cnt_idx) == i) m_cnt[tt][i] = int'(cnt_wdata);
        else if (tt == t && ch[i] && m_cnt[tt][i] > 1) m_cnt[tt][i]--;
        else if (tt == t && ch[i] && m_cnt[tt][i] == 1) m_cnt[tt][i] = 0;
        if (tt == t && f[i]) m_hit[tt][i] = 1'b1;
        else if (hit_clr[tt][i]) m_hit[tt][i] = 1'b0;
      end
    if ((d3.valid && d3.store && any_m()) || clk_override) begin
      v = d3.atomic ? lsu.amo_data_dc3 : lsu.store_data_dc3;
      if (d3.word || d3.dword) m_sd = v;
      else if (d3.by)          m_sd = v & 32'h0000_00FF;
      else                     m_sd = v & 32'h0000_FFFF;
    end
  endtask

  task automatic model_reset();
    m_sd = 32'h0;
    foreach (m_cnt[a, b]) begin m_cnt[a][b] = 0; m_hit[a][b] = 1'b0; end
  endtask

  // Called just after a falling edge with the cycle's inputs already driven.
  task automatic tick();
    logic [NG-1:0] ch;
    logic [NG-1:0] f;
    #1;
    f = model_fire(ch);
    chk("match", 32'(lsu.lsu_trigger_match_dc4), 32'(f));
    model_step(f, ch);
    @(posedge clk);
    #1;
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NG; i++) begin
        chk($sformatf("cnt[%0d][%0d]", t, i), 32'(cnt_rd[t][i]), 32'(m_cnt[t][i]));
        chk($sformatf("hit[%0d][%0d]", t, i), 32'(hit[t][i]), 32'(m_hit[t][i]));
      end
    @(negedge clk);
  endtask

  task automatic expect_match(input string tag, input logic [NG-1:0] exp);
    #1;
    chk(tag, 32'(lsu.lsu_trigger_match_dc4), 32'(exp));
  endtask

  task automatic idle();
    lsu.lsu_pkt_dc3 = '0;      lsu.lsu_pkt_dc4 = '0;
    lsu.lsu_kill_dc4 = 1'b0;   lsu.lsu_addr_dc4 = 32'h0;
    lsu.store_data_dc3 = 32'h0; lsu.amo_data_dc3 = 32'h0;
    cnt_wr = 1'b0; cnt_tid = 1'b0; cnt_idx = 2'd0; cnt_wdata = '0;
    clk_override = 1'b0;
    foreach (hit_clr[t]) hit_clr[t] = '0;
  endtask

  task automatic clear_trigs();
    foreach (trig[a, b]) begin trig[a][b] = '0; mode[a][b] = 2'b11; end
    foreach (chain[a]) chain[a] = '0;
  endtask

  task automatic set_trig(input int t, input int i, input bit sel, input bit st, input bit ld,
                          input bit msk, input logic [31:0] td, input logic [1:0] md);
    trig[t][i].m = 1'b1;      trig[t][i].select = sel; trig[t][i].match = msk;
    trig[t][i].store = st;    trig[t][i].load = ld;    trig[t][i].tdata2 = td;
    mode[t][i] = md;
  endtask

  function automatic eh2_lsu_pkt_t mkpkt(bit ld, bit st, int sz, bit tid);
    eh2_lsu_pkt_t p;
    p = '0; p.valid = 1'b1; p.load = ld; p.store = st; p.tid = tid;
    case (sz)
      0:       p.by = 1'b1;
      1:       p.half = 1'b1;
      2:       p.word = 1'b1;
      default: p.dword = 1'b1;
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 32'h1000;  1: return 32'h1004;  2: return 32'h2000;  3: return 32'h2008;
      4: return 32'h3000;  5: return 32'h1007;  6: return 32'h0000_00AB;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          seq [4] = '{2, 1, 0, 0};
    int          sz;
    logic [31:0] tmp;
    idle();
    clear_trigs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_match", 32'(lsu.lsu_trigger_match_dc4), 32'h0);
    for (int t = 0; t < NT; t++)
      for (int i = 0; i < NG; i++) begin
        chk("reset_cnt", 32'(cnt_rd[t][i]), 32'h0);
        chk("reset_hit", 32'(hit[t][i]), 32'h0);
      end
    rst_l = 1'b1;
    @(negedge clk);

    // Word store hitting an exact address trigger.
    set_trig(0, 0, 0, 1, 0, 0, 32'h1000, 2'b00);
    lsu.lsu_pkt_dc4 = mkpkt(0, 1, 2, 0); lsu.lsu_addr_dc4 = 32'h1000;
    expect_match("store_word_match", 4'b0001);
    tick();
    chk("store_word_hit", 32'(hit[0][0]), 32'h1);
    idle();

    // Load inside [0x2000, 0x2008) via two range triggers.
    set_trig(0, 1, 0, 0, 1, 0, 32'h2000, 2'b01);
    set_trig(0, 2, 0, 0, 1, 0, 32'h2008, 2'b10);
    lsu.lsu_pkt_dc4 = mkpkt(1, 0, 2, 0); lsu.lsu_addr_dc4 = 32'h2004;
    expect_match("range_match", 4'b0110);
    tick();
    idle();

    // Chained address + store-data pair.
    clear_trigs();
    set_trig(0, 0, 0, 1, 0, 0, 32'h3000, 2'b00);
    set_trig(0, 1, 1, 1, 0, 0, 32'h0000_00AB, 2'b00);
    chain[0][0] = 1'b1;
    lsu.lsu_pkt_dc3 = mkpkt(0, 1, 0, 0); lsu.store_data_dc3 = 32'h1234_56AB;
    tick();
    lsu.lsu_pkt_dc4 = mkpkt(0, 1, 0, 0); lsu.lsu_addr_dc4 = 32'h3000;
    lsu.store_data_dc3 = 32'h1234_56AC;
    expect_match("chain_match", 4'b0011);
    tick();
    lsu.lsu_pkt_dc3 = '0;
    expect_match("chain_data_miss", 4'b0000);
    tick();
    idle();

    // Match counter preset to 3.
    clear_trigs();
    set_trig(0, 0, 0, 1, 0, 0, 32'h1000, 2'b00);
    cnt_wr = 1'b1; cnt_wdata = 8'd3;
    tick();
    cnt_wr = 1'b0;
    chk("cnt_load", 32'(cnt_rd[0][0]), 32'd3);
    for (int k = 0; k < 4; k++) begin
      lsu.lsu_pkt_dc4 = mkpkt(0, 1, 2, 0); lsu.lsu_addr_dc4 = 32'h1000;
      expect_match($sformatf("cnt_gate%0d", k), (k >= 2) ? 4'b0001 : 4'b0000);
      tick();
      chk($sformatf("cnt_seq%0d", k), 32'(cnt_rd[0][0]), 32'(seq[k]));
    end

    // Set beats clear; counter write beats decrement.
    hit_clr[0][0] = 1'b1;
    tick();
    chk("hit_set_wins", 32'(hit[0][0]), 32'h1);
    lsu.lsu_pkt_dc4 = '0;
    tick();
    chk("hit_clear", 32'(hit[0][0]), 32'h0);
    hit_clr[0][0] = 1'b0;
    cnt_wr = 1'b1; cnt_wdata = 8'd2;
    tick();
    lsu.lsu_pkt_dc4 = mkpkt(0, 1, 2, 0); cnt_wdata = 8'd5;
    tick();
    chk("cnt_wr_wins", 32'(cnt_rd[0][0]), 32'd5);
    cnt_wr = 1'b0;

    // Flushed op neither matches nor counts.
    lsu.lsu_kill_dc4 = 1'b1;
    expect_match("kill_match", 4'b0000);
    tick();
    chk("kill_cnt", 32'(cnt_rd[0][0]), 32'd5);
    lsu.lsu_kill_dc4 = 1'b0;

    // Asynchronous reset mid-stream.
    rst_l = 1'b0;
    model_reset();
    #1;
    chk("rst_cnt", 32'(cnt_rd[0][0]), 32'h0);
    for (int i = 0; i < NG; i++) chk("rst_hit", 32'(hit[0][i]), 32'h0);
    @(negedge clk);
    rst_l = 1'b1;
    idle();

    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        foreach (trig[a, b]) begin
          trig[a][b].m      = ($urandom_range(0, 7) != 0) && (n % 512 != 256);
          trig[a][b].select = 1'($urandom);
          trig[a][b].match  = 1'($urandom);
          trig[a][b].store  = 1'($urandom);
          trig[a][b].load   = 1'($urandom);
          trig[a][b].tdata2 = pick_addr();
          mode[a][b]        = 2'($urandom);
        end
        foreach (chain[a]) chain[a] = NG'($urandom);
      end
      if (n == 1500) begin
        rst_l = 1'b0;
        model_reset();
        @(negedge clk);
        rst_l = 1'b1;
      end
      sz  = $urandom_range(0, 3);
      tmp = pick_addr();
      lsu.lsu_pkt_dc3 = mkpkt(1'($urandom), 1'($urandom), sz, 1'($urandom));
      lsu.lsu_pkt_dc3.valid  = ($urandom_range(0, 3) != 0);
      lsu.lsu_pkt_dc3.atomic = ($urandom_range(0, 3) == 0);
      lsu.store_data_dc3 = (tmp == 32'h3000) ? $urandom : tmp;
      lsu.amo_data_dc3   = pick_addr();
      sz = $urandom_range(0, 2);
      lsu.lsu_pkt_dc4 = mkpkt(sz != 1, sz != 0, $urandom_range(0, 3), 1'($urandom));
      lsu.lsu_pkt_dc4.valid = ($urandom_range(0, 3) != 0);
      lsu.lsu_pkt_dc4.dma   = ($urandom_range(0, 15) == 0);
      lsu.lsu_kill_dc4      = ($urandom_range(0, 7) == 0);
      lsu.lsu_addr_dc4      = pick_addr();
      cnt_wr    = ($urandom_range(0, 7) == 0);
      cnt_tid   = 1'($urandom);
      cnt_idx   = 2'($urandom);
      cnt_wdata = CW'($urandom_range(0, 4));
      foreach (hit_clr[a]) hit_clr[a] = ($urandom_range(0, 7) == 0) ? NG'($urandom) : '0;
      clk_override = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
